// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline boundary register with a 2-entry skid buffer and a saturating
// MEM-side stall counter for performance debug.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              alu_zero_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic [3:0]        ctrl_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] alu_data_o,
    output logic              alu_zero_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [3:0]        ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_data;
        logic              alu_zero;
        logic [DATA_W-1:0] rs2_data;
        logic [RD_W-1:0]   rd;
        logic [3:0]        ctrl;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state, state_next;
    entry_t           main_entry, skid_entry, in_entry;
    logic             accept, pop;
    logic             load_main_in, load_main_skid, load_skid;
    logic [CNT_W-1:0] stall_cnt;

    assign in_entry = '{alu_data: alu_data_i, alu_zero: alu_zero_i,
                        rs2_data: rs2_data_i, rd: rd_i, ctrl: ctrl_i};

    // ready is a decode of the state register only, so there is no path from mem_ready_i
    assign ex_ready_o  = (state != FULL);
    assign mem_valid_o = (state != EMPTY);
    assign accept      = ex_valid_i & ex_ready_o;
    assign pop         = mem_valid_o & mem_ready_i;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) begin
                    load_main_in = 1'b1;
                    state_next   = ONE;
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    load_main_skid = 1'b1;
                    state_next     = ONE;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments; payload registers are reset too
    // because the outputs must read 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= EMPTY;
            main_entry <= '0;
            skid_entry <= '0;
        end else begin
            state <= state_next;
            if (load_main_in)        main_entry <= in_entry;
            else if (load_main_skid) main_entry <= skid_entry;
            if (load_skid)           skid_entry <= in_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (mem_valid_o && !mem_ready_i && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign alu_data_o  = main_entry.alu_data;
    assign alu_zero_o  = main_entry.alu_zero;
    assign rs2_data_o  = main_entry.rs2_data;
    assign rd_o        = main_entry.rd;
    assign ctrl_o      = main_entry.ctrl;
    assign stall_cnt_o = stall_cnt;

endmodule
